// File: rtl/scan_pkg.sv
// scan_pkg: shared state encoding, channel-count constants and lowest-channel helper
package scan_pkg;
  localparam int N_CH = 4;
  localparam int CH_W = 2;
  localparam int BLANK_CYC_DEF = 4;
  typedef enum logic [1:0] {IDLE, DWELL, BLANK} state_e;
  function automatic logic [CH_W-1:0] lowest_ch(input logic [N_CH-1:0] m);
    lowest_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) if (m[i]) lowest_ch = CH_W'(i);
  endfunction
endpackage

// File: rtl/scan_next_ch.sv
// scan_next_ch: lowest enabled channel strictly above cur_i, else lowest enabled with wrap_o
module scan_next_ch import scan_pkg::*; (
  input  logic [N_CH-1:0] ch_mask_i,
  input  logic [CH_W-1:0] cur_i,
  output logic [CH_W-1:0] nxt_o,
  output logic            wrap_o
);
  always_comb begin
    nxt_o = lowest_ch(ch_mask_i);
    wrap_o = 1'b1;
    for (int i = N_CH - 1; i >= 0; i--)
      if (ch_mask_i[i] && CH_W'(i) > cur_i) begin
        nxt_o = CH_W'(i);
        wrap_o = 1'b0;
      end
  end
endmodule

// File: rtl/scan_sequencer.sv
// scan_sequencer: round-robin channel scanner with per-channel dwell and optional blanking
module scan_sequencer import scan_pkg::*; #(
  parameter int CNT_W = 16,
  parameter int BLANK_CYC = BLANK_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] dwell,
  input  logic [N_CH-1:0]  ch_mask,
  output logic [CH_W-1:0]  sel,
  output logic             sel_valid,
  output logic             frame_done
);
  localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYC == 0 ? 0 : BLANK_CYC - 1);
  state_e state_q, state_d;
  logic [CH_W-1:0] sel_q, sel_d, nxt_ch;
  logic sel_valid_q, sel_valid_d, frame_done_q, frame_done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, dwell_ld;
  logic wrap, stop, cnt_zero, entering, advance;
  assign stop = !en || ch_mask == '0;
  assign cnt_zero = cnt_q == '0;
  assign dwell_ld = dwell == '0 ? '0 : dwell - 1'b1;
  assign entering = state_q == IDLE && state_d == DWELL;
  assign advance = state_q != IDLE && state_d == DWELL && cnt_zero;
  assign sel = sel_q;
  assign sel_valid = sel_valid_q;
  assign frame_done = frame_done_q;
  scan_next_ch u_next (
    .ch_mask_i(ch_mask),
    .cur_i    (sel_q),
    .nxt_o    (nxt_ch),
    .wrap_o   (wrap)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q <= '0;
      sel_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      sel_valid_q <= sel_valid_d;
      frame_done_q <= frame_done_d;
      cnt_q <= cnt_d;
    end
  always_comb begin
    state_d = state_q;
    if (stop) state_d = IDLE;
    else if (state_q == IDLE) state_d = DWELL;
    else if (cnt_zero) state_d = (state_q == DWELL && BLANK_CYC > 0) ? BLANK : DWELL;
  end
  // the counter saturates at zero so a held state can never wrap it
  always_comb begin
    sel_d = entering ? lowest_ch(ch_mask) : advance ? nxt_ch : sel_q;
    sel_valid_d = state_d == DWELL;
    frame_done_d = advance && wrap;
    cnt_d = (entering || advance) ? dwell_ld :
            (state_q == DWELL && state_d == BLANK) ? BLANK_LD :
            (state_d == IDLE || cnt_zero) ? '0 : cnt_q - 1'b1;
  end
endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: visit-level scoreboard against a mask/dwell reference model
module tb_scan_sequencer;
  localparam int B = 2;
  logic clk = 0, rst_n = 1, en = 0;
  logic [15:0] dwell = 0;
  logic [3:0] ch_mask = 0;
  logic [1:0] sel;
  logic sel_valid, frame_done;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {logic [1:0] sel; int len; logic fd; int start;} visit_t;
  visit_t exp_q[$];
  visit_t got, e;
  logic in_v = 0;

  scan_sequencer #(.CNT_W(16), .BLANK_CYC(B)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dwell(dwell), .ch_mask(ch_mask),
    .sel(sel), .sel_valid(sel_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int low(input logic [3:0] m);
    for (int c = 0; c < 4; c++) if (m[c]) return c;
    return 0;
  endfunction

  function automatic int succ(input logic [3:0] m, input int cur);
    for (int c = cur + 1; c < 4; c++) if (m[c]) return c;
    return low(m);
  endfunction

  task automatic chk(input string nm, input int g, input int r);
    checks++;
    if (g != r) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", nm, g, r);
    end
  endtask

  // one visit = a contiguous run of sel_valid with constant sel
  always @(negedge clk) begin
    checks++;
    if (frame_done && !(sel_valid && !in_v)) begin
      errors++;
      $display("FAIL frame_done_placement cyc=%0d got=1 required=0", cyc);
    end
    if (sel_valid && !in_v) begin
      in_v = 1;
      got = '{sel, 1, frame_done, cyc};
    end else if (sel_valid) begin
      got.len++;
      if (sel != got.sel) begin
        errors++;
        $display("FAIL sel_hold cyc=%0d got=%0d required=%0d", cyc, sel, got.sel);
      end
    end else if (in_v) begin
      in_v = 0;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_visit sel=%0d len=%0d start=%0d required none", got.sel, got.len, got.start);
      end else begin
        e = exp_q.pop_front();
        if (got.sel != e.sel || got.len != e.len || got.fd != e.fd || got.start != e.start) begin
          errors++;
          $display("FAIL visit got sel=%0d len=%0d fd=%0d start=%0d required sel=%0d len=%0d fd=%0d start=%0d",
                   got.sel, got.len, got.fd, got.start, e.sel, e.len, e.fd, e.start);
        end
      end
    end
  end

  // enable for kn full visits (each ending with its blank); mask switches to mb at offset sw
  task automatic run(input logic [3:0] ma, input logic [3:0] mb, input int sw, input int dw, input int kn);
    int n, dd, p, cur, nx;
    n = cyc;
    dd = dw == 0 ? 1 : dw;
    p = dd + B;
    ch_mask = ma;
    dwell = 16'(dw);
    en = 1;
    cur = low(ma);
    exp_q.push_back('{2'(cur), dd, 1'b0, n + 1});
    for (int k = 1; k < kn; k++) begin
      nx = succ(k * p >= sw ? mb : ma, cur);
      exp_q.push_back('{2'(nx), dd, nx <= cur, n + 1 + k * p});
      cur = nx;
    end
    for (int t = 1; t <= kn * p; t++) begin
      @(negedge clk);
      if (t == sw) ch_mask = mb;
    end
    en = 0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n, m, mb, d, k, sw;
    #1 rst_n = 0;
    #1;
    chk("reset_sel", sel, 0);
    chk("reset_valid", sel_valid, 0);
    chk("reset_fd", frame_done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run(4'b1111, 4'b1111, 0, 3, 6);
    run(4'b1010, 4'b1010, 0, 1, 4);
    run(4'b0110, 4'b0110, 0, 0, 5);
    run(4'b0100, 4'b0100, 0, 2, 3);
    en = 1;
    ch_mask = 4'b0000;
    repeat (5) @(negedge clk);
    en = 0;
    n = cyc;
    ch_mask = 4'b1100;
    dwell = 16'd5;
    en = 1;
    exp_q.push_back('{2'd2, 2, 1'b0, n + 1});
    repeat (2) @(negedge clk);
    en = 0;
    repeat (3) @(negedge clk);
    run(4'b1100, 4'b1100, 0, 2, 3);
    run(4'b1111, 4'b0100, 6, 3, 5);
    n = cyc;
    ch_mask = 4'b1000;
    dwell = 16'd2;
    en = 1;
    exp_q.push_back('{2'd3, 2, 1'b0, n + 1});
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_sel", sel, 0);
    chk("async_valid", sel_valid, 0);
    chk("async_fd", frame_done, 0);
    en = 0;
    @(negedge clk);
    chk("held_reset_fd", frame_done, 0);
    rst_n = 1;
    @(negedge clk);
    run(4'b1000, 4'b1000, 0, 2, 2);
    repeat (8) begin
      m = $urandom_range(1, 15);
      mb = $urandom_range(1, 15);
      d = $urandom_range(0, 4);
      k = $urandom_range(1, 5);
      sw = $urandom_range(1, k * ((d == 0 ? 1 : d) + B));
      run(4'(m), 4'(mb), sw, d, k);
    end
    repeat (5) @(negedge clk);
    chk("pending_visits", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameter CNT_W, default 16, is the width of the dwell counter and of the dwell input.
REQ-002 Parameter BLANK_CYC, default 4, is the number of blanking cycles between channels (0 = no blanking).
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port en, input, 1: scan enable.
REQ-006 Port dwell, input, CNT_W: number of cycles each channel is held selected; 0 is treated as 1.
REQ-007 Port ch_mask, input, 4: per-channel enable, bit i = 1 includes channel i in the scan.
REQ-008 Port sel, output, 2: channel code driven to the downstream 2-to-4 decoder.
REQ-009 Port sel_valid, output, 1: high while sel is in its dwell phase; downstream gates the decoded one-hot with it.
REQ-010 Port frame_done, output, 1: one-cycle pulse when the scan wraps from the highest enabled channel to the lowest.
REQ-011 All outputs shall be registered.

Function
REQ-012 The FSM shall have exactly three states: IDLE, DWELL and BLANK.
REQ-013 IDLE behaviour: sel_valid = 0 and sel holds its last value.
REQ-014 IDLE exit: on a cycle where en = 1 and ch_mask != 0, the next state is DWELL, sel = lowest set bit of ch_mask and sel_valid = 1 on the following cycle (latency 1).
REQ-015 DWELL duration: sel_valid = 1 for exactly max(dwell, 1) cycles; dwell is sampled when the channel is entered, and later changes apply at the next channel.
REQ-016 DWELL end, BLANK_CYC > 0: enter BLANK with sel_valid = 0 and sel unchanged for exactly BLANK_CYC cycles.
REQ-017 DWELL end, BLANK_CYC = 0: advance directly to the next channel in DWELL; sel_valid stays 1 and sel changes in the same cycle.
REQ-018 Channel advance: the next channel is the lowest enabled channel strictly above the current one in the ch_mask sampled at advance time.
REQ-019 Wrap-around: if no enabled channel is above the current one, wrap to the lowest enabled channel and assert frame_done for exactly one cycle, coincident with the first cycle of the new channel.
REQ-020 Single enabled channel: sel stays constant, blanking still occurs, and frame_done pulses on every pass.
REQ-021 Current channel masked mid-dwell: the dwell completes normally, then the sequencer advances per REQ-018.
REQ-022 Stop on disable: if en = 0 or ch_mask = 0 in any state, the next state is IDLE with sel_valid = 0 the following cycle; this condition takes priority over any advance.
REQ-023 Wrap-cycle stop: frame_done shall not pulse on a cycle in which REQ-022 forces IDLE.
REQ-024 Counter arithmetic: the dwell/blank counter is CNT_W bits, loads count-1 and decrements to 0; it shall never underflow or wrap.

Reset
REQ-025 While rst_n = 0 (asynchronous): state = IDLE, sel = 2'b00, sel_valid = 0, frame_done = 0, counter = 0.
REQ-026 Reset mid-DWELL or mid-BLANK shall abort immediately with no frame_done pulse.
REQ-027 After rst_n deasserts, the first DWELL starts per REQ-014.

Structure
REQ-028 Shared package scan_pkg shall hold the state enum (IDLE/DWELL/BLANK), the channel-count constant 4 and the default BLANK_CYC.
REQ-029 One combinational sub-module, scan_next_ch, shall take (ch_mask, current sel) and return the next channel plus a wrap flag.
REQ-030 The sel output shall connect unmodified to the existing 2-to-4 decoder's data input.

Verification
REQ-031 Full mask: ch_mask=4'b1111, dwell=3, BLANK_CYC=2, en=1 -> sel 0,1,2,3,0..., each sel_valid high 3 cycles then low 2; frame_done pulses on re-entry to 0.
REQ-032 Sparse mask: ch_mask=4'b1010, dwell=1 -> sel alternates 1,3,1; frame_done pulses on each entry to 1 after the first.
REQ-033 Zero dwell: dwell=0 -> each channel has sel_valid high exactly 1 cycle.
REQ-034 Disable mid-dwell: en drops in cycle 2 of a 5-cycle dwell -> sel_valid = 0 next cycle, state IDLE; re-enable restarts at the lowest enabled channel.
REQ-035 Async reset: rst_n pulsed low mid-BLANK between clock edges -> outputs go to reset values immediately with no frame_done pulse.
REQ-036 Mask change: ch_mask changes from 4'b1111 to 4'b0100 during channel 1's dwell -> dwell completes, next sel = 2, then 2 repeats with frame_done each pass.
